// File: rtl/operand_pkg.sv
// Shared key codes and state encoding for the operand entry block.
package operand_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_ENTER     = 4'hA;
    localparam logic [3:0] KEY_CLEAR     = 4'hB;
    localparam logic [3:0] KEY_BKSP      = 4'hC;

    typedef enum logic [1:0] {
        ENT_A = 2'd0,
        ENT_B = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } phase_t;

endpackage

// File: rtl/bcd_to_bin.sv
// Combinational BCD to binary converter (Horner's rule, most significant digit first).
module bcd_to_bin #(
    parameter int N_DIGITS = 2,
    parameter int OP_W     = 8
) (
    input  logic [4*N_DIGITS-1:0] bcd,
    output logic [OP_W-1:0]       bin
);

    always_comb begin
        // NOTE: blocking assignments here build a combinational chain; the
        // default assignment first also keeps this block free of latches.
        bin = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            bin = bin * OP_W'(10) + OP_W'(bcd[4*i +: 4]);
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Collects two decimal operands from the keypad and launches the multiplier.
// Optional feature: define OPERAND_BKSP_EN to make key 0xC a backspace.
module operand_entry
    import operand_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter int OP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_available,
    input  logic [3:0]            dato_o,
    input  logic                  mult_done,
    output logic [OP_W-1:0]       op_a,
    output logic [OP_W-1:0]       op_b,
    output logic                  mult_start,
    output logic                  busy,
    output logic [1:0]            phase,
    output logic [4*N_DIGITS-1:0] disp_bcd
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(N_DIGITS + 1);

    if ((64'd1 << OP_W) <= 64'(10 ** N_DIGITS - 1)) begin : g_bad_width
        $error("operand_entry: OP_W too narrow for N_DIGITS decimal digits");
    end

    phase_t           state;
    logic             prev_da;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  bin;
    logic             key_edge;
    logic             is_digit;
    logic             room;

    // armed blocks a key held across reset release from counting as a press
    assign key_edge = data_available & ~prev_da & armed;
    assign is_digit = (dato_o <= KEY_MAX_DIGIT);
    assign room     = (cnt < CNT_W'(N_DIGITS));
    assign phase    = state;

    bcd_to_bin #(
        .N_DIGITS (N_DIGITS),
        .OP_W     (OP_W)
    ) u_conv (
        .bcd (disp_bcd),
        .bin (bin)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= ENT_A;
            prev_da    <= 1'b0;
            armed      <= 1'b0;
            cnt        <= '0;
            disp_bcd   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            mult_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            prev_da    <= data_available;
            armed      <= 1'b1;
            mult_start <= 1'b0;
            case (state)
                ENT_A, ENT_B: begin
                    if (key_edge) begin
                        if (is_digit) begin
                            if (room) begin
                                disp_bcd <= (disp_bcd << 4) | BCD_W'(dato_o);
                                cnt      <= cnt + CNT_W'(1);
                            end
                        end else if (dato_o == KEY_ENTER) begin
                            disp_bcd <= '0;
                            cnt      <= '0;
                            if (state == ENT_A) begin
                                op_a  <= bin;
                                state <= ENT_B;
                            end else begin
                                op_b       <= bin;
                                mult_start <= 1'b1;
                                busy       <= 1'b1;
                                state      <= WAIT;
                            end
                        end else if (dato_o == KEY_CLEAR) begin
                            disp_bcd <= '0;
                            cnt      <= '0;
                            op_a     <= '0;
                            op_b     <= '0;
                            state    <= ENT_A;
                        end
`ifdef OPERAND_BKSP_EN
                        else if (dato_o == KEY_BKSP) begin
                            disp_bcd <= disp_bcd >> 4;
                            if (cnt != '0) cnt <= cnt - CNT_W'(1);
                        end
`endif
                    end
                end
                WAIT: begin
                    // key edges here are deliberately dropped, not queued
                    if (mult_done) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (key_edge) begin
                        if (is_digit) begin
                            disp_bcd <= BCD_W'(dato_o);
                            cnt      <= CNT_W'(1);
                            state    <= ENT_A;
                        end else if (dato_o == KEY_CLEAR) begin
                            disp_bcd <= '0;
                            cnt      <= '0;
                            op_a     <= '0;
                            op_b     <= '0;
                            state    <= ENT_A;
                        end
                    end
                end
                default: state <= ENT_A;
            endcase
        end
    end

endmodule
